// File: rtl/key_event_detect_pkg.sv
// Shared definitions for the key gesture classifier: FSM states, event bit
// positions and the parameter range check used at elaboration.
package key_event_detect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,  // no gesture in progress
    ST_PRESS1 = 3'd1,  // first press held, timing toward long-press
    ST_WAIT2  = 3'd2,  // first tap released, waiting for a second press
    ST_PRESS2 = 3'd3,  // second press held
    ST_LONG   = 3'd4   // long-hold reached, emitting auto-repeat
  } state_e;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_CLICK   = 2;
  localparam int EV_DBL     = 3;
  localparam int EV_LONG    = 4;
  localparam int EV_REPEAT  = 5;
  localparam int EV_W       = 6;

  // A cycle count is usable when its expiry value (count-1) fits the counter.
  function automatic bit cyc_fits(input longint cyc, input int width);
    return (cyc >= 1) && (cyc <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/key_event_detect_timer.sv
// Event timer: saturating up-counter with synchronous clear and a terminal
// compare against a limit chosen by the caller each cycle.
module key_event_detect_timer #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == limit);

endmodule

// File: rtl/key_event_detect.sv
// Classifies a debounced key level into single-cycle gesture pulses:
// press, release, click, double-click, long-press and auto-repeat.
module key_event_detect
  import key_event_detect_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter int CNT_W      = 20,
  parameter int LONG_CYC   = 1_000_000,
  parameter int DBL_CYC    = 300_000,
  parameter int REPEAT_CYC = 200_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_pressed,
  output logic ev_press,
  output logic ev_release,
  output logic ev_click,
  output logic ev_dbl,
  output logic ev_long,
  output logic ev_repeat
);

  if (!cyc_fits(longint'(LONG_CYC), CNT_W) || !cyc_fits(longint'(DBL_CYC), CNT_W) ||
      !cyc_fits(longint'(REPEAT_CYC), CNT_W)) begin : g_param_err
    $error("key_event_detect: cycle parameter out of range for CNT_W");
  end

  // Expiry happens when the counter reads one less than the cycle count.
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LIM  = CNT_W'(REPEAT_CYC - 1);
  localparam logic             REL_LVL  = ACTIVE_LOW;

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            p_dly_q, p_dly_d;
  state_e          state_q, state_d;
  logic [EV_W-1:0] ev_q, ev_d;

  logic             p_lvl;
  logic             rise;
  logic             fall;
  logic             rpt_restart;
  logic             tmr_clr;
  logic             tmr_tc;
  logic [CNT_W-1:0] tmr_limit;

  assign p_lvl = s2_q ^ ACTIVE_LOW;
  assign rise  = p_lvl & ~p_dly_q;
  assign fall  = ~p_lvl & p_dly_q;

  always_comb begin
    s1_d    = key_in;
    s2_d    = s1_q;
    p_dly_d = p_lvl;
  end

  // Input edges are checked before expiries so an edge always wins a tie.
  always_comb begin
    state_d     = state_q;
    ev_d        = '0;
    rpt_restart = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d          = ST_PRESS1;
          ev_d[EV_PRESS]   = 1'b1;
        end
      end
      ST_PRESS1: begin
        if (fall) begin
          state_d          = ST_WAIT2;
          ev_d[EV_RELEASE] = 1'b1;
        end else if (tmr_tc) begin
          state_d          = ST_LONG;
          ev_d[EV_LONG]    = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (rise) begin
          state_d          = ST_PRESS2;
          ev_d[EV_PRESS]   = 1'b1;
        end else if (tmr_tc) begin
          state_d          = ST_IDLE;
          ev_d[EV_CLICK]   = 1'b1;
        end
      end
      ST_PRESS2: begin
        if (fall) begin
          state_d          = ST_IDLE;
          ev_d[EV_RELEASE] = 1'b1;
          ev_d[EV_DBL]     = 1'b1;
        end else if (tmr_tc) begin
          // The first tap is still reported when the second becomes a hold.
          state_d          = ST_LONG;
          ev_d[EV_CLICK]   = 1'b1;
          ev_d[EV_LONG]    = 1'b1;
        end
      end
      ST_LONG: begin
        if (fall) begin
          state_d          = ST_IDLE;
          ev_d[EV_RELEASE] = 1'b1;
        end else if (tmr_tc) begin
          ev_d[EV_REPEAT]  = 1'b1;
          rpt_restart      = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    tmr_limit = '1;
    case (state_q)
      ST_PRESS1, ST_PRESS2: tmr_limit = LONG_LIM;
      ST_WAIT2:             tmr_limit = DBL_LIM;
      ST_LONG:              tmr_limit = REP_LIM;
      default:              tmr_limit = '1;
    endcase
  end

  assign tmr_clr = (state_d != state_q) | rpt_restart;

  key_event_detect_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (1'b1),
    .limit (tmr_limit),
    .tc    (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= REL_LVL;
      s2_q    <= REL_LVL;
      p_dly_q <= 1'b0;
      state_q <= ST_IDLE;
      ev_q    <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      p_dly_q <= p_dly_d;
      state_q <= state_d;
      ev_q    <= ev_d;
    end
  end

  assign key_pressed = p_dly_q;
  assign ev_press    = ev_q[EV_PRESS];
  assign ev_release  = ev_q[EV_RELEASE];
  assign ev_click    = ev_q[EV_CLICK];
  assign ev_dbl      = ev_q[EV_DBL];
  assign ev_long     = ev_q[EV_LONG];
  assign ev_repeat   = ev_q[EV_REPEAT];

endmodule

// File: tb/tb_key_event_detect.sv
// Bench for key_event_detect: an active-high and an active-low instance see
// the same gestures and are both checked every cycle against a gesture model.
module tb_key_event_detect;

  localparam int MAXC   = 20000;
  localparam int T_LONG = 20;
  localparam int T_DBL  = 10;
  localparam int T_REP  = 5;

  typedef struct {
    string name;
    int    p1;
    int    gap;
    int    p2;
    int    tail;
    int    n_press;
    int    n_rel;
    int    n_click;
    int    n_dbl;
    int    n_long;
    int    n_rep;
    int    click_off;
    int    long_off;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key = 1'b0;
  logic key_n = 1'b1;

  logic kp_h, pr_h, rl_h, ck_h, db_h, lg_h, rp_h;
  logic kp_l, pr_l, rl_l, ck_l, db_l, lg_l, rp_l;

  key_event_detect #(
    .ACTIVE_LOW (1'b0), .CNT_W (5), .LONG_CYC (T_LONG), .DBL_CYC (T_DBL), .REPEAT_CYC (T_REP)
  ) u_dut_hi (
    .clk (clk), .rst_n (rst_n), .key_in (key), .key_pressed (kp_h),
    .ev_press (pr_h), .ev_release (rl_h), .ev_click (ck_h), .ev_dbl (db_h),
    .ev_long (lg_h), .ev_repeat (rp_h)
  );

  key_event_detect #(
    .ACTIVE_LOW (1'b1), .CNT_W (5), .LONG_CYC (T_LONG), .DBL_CYC (T_DBL), .REPEAT_CYC (T_REP)
  ) u_dut_lo (
    .clk (clk), .rst_n (rst_n), .key_in (key_n), .key_pressed (kp_l),
    .ev_press (pr_l), .ev_release (rl_l), .ev_click (ck_l), .ev_dbl (db_l),
    .ev_long (lg_l), .ev_repeat (rp_l)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  bit hist [0:MAXC];
  bit rstv [0:MAXC];

  // Gesture model: timestamps of the last press/release/long event.
  bit m_active, m_wait, m_long;
  int m_taps, t_press, t_rel, t_long;

  logic [6:0] obs_hi;
  int sc_press, sc_rel, sc_click, sc_dbl, sc_long, sc_rep;
  int sc_first_rel, sc_last_press, sc_click_off, sc_long_off;

  // Vector layout: {key_pressed, press, release, click, dbl, long, repeat}.
  task automatic model_step(input int n, output logic [6:0] e);
    bit lnow, lprev, press, rel;
    e = '0;
    if (n < 1 || !rstv[n-1]) begin
      m_active = 0; m_wait = 0; m_long = 0; m_taps = 0;
      return;
    end
    lnow  = (n >= 3) ? hist[n-3] : 1'b0;
    lprev = (n >= 4) ? hist[n-4] : 1'b0;
    press = lnow & ~lprev;
    rel   = ~lnow & lprev;
    e[6]  = lnow;
    if (press) begin
      e[5] = 1'b1;
      if (!m_active) begin m_active = 1; m_taps = 1; m_long = 0; end
      else m_taps = 2;
      m_wait = 0; t_press = n;
    end else if (rel) begin
      e[4] = 1'b1;
      if (m_long) begin m_active = 0; m_long = 0; end
      else if (m_taps == 2) begin e[2] = 1'b1; m_active = 0; end
      else begin m_wait = 1; t_rel = n; end
    end else if (lnow && m_active && !m_long && (n - t_press) == T_LONG) begin
      e[1] = 1'b1; m_long = 1; t_long = n;
      if (m_taps == 2) e[3] = 1'b1;
    end else if (lnow && m_long && n > t_long && ((n - t_long) % T_REP) == 0) begin
      e[0] = 1'b1;
    end else if (m_active && m_wait && (n - t_rel) == T_DBL) begin
      e[3] = 1'b1; m_active = 0; m_wait = 0;
    end
  endtask

  task automatic chk_vec(input string nm, input logic [6:0] got, input logic [6:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    cmp_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  task automatic step(input bit k, input bit r);
    logic [6:0] e;
    @(negedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    model_step(cyc, e);
    obs_hi = {kp_h, pr_h, rl_h, ck_h, db_h, lg_h, rp_h};
    chk_vec("model_al0", obs_hi, e);
    chk_vec("model_al1", {kp_l, pr_l, rl_l, ck_l, db_l, lg_l, rp_l}, e);
    if (obs_hi[5]) begin sc_press++; sc_last_press = cyc; end
    if (obs_hi[4]) begin sc_rel++; if (sc_first_rel < 0) sc_first_rel = cyc; end
    if (obs_hi[3]) begin
      sc_click++;
      if (sc_click_off < 0 && sc_first_rel >= 0) sc_click_off = cyc - sc_first_rel;
    end
    if (obs_hi[2]) sc_dbl++;
    if (obs_hi[1]) begin sc_long++; if (sc_long_off < 0) sc_long_off = cyc - sc_last_press; end
    if (obs_hi[0]) sc_rep++;
    key = k; key_n = ~k; rst_n = r;
    rstv[cyc] = r;
    hist[cyc] = r & k;
  endtask

  task automatic run_vec(input vec_t v);
    sc_press = 0; sc_rel = 0; sc_click = 0; sc_dbl = 0; sc_long = 0; sc_rep = 0;
    sc_first_rel = -1; sc_last_press = -1; sc_click_off = -1; sc_long_off = -1;
    repeat (3) step(1'b0, 1'b1);
    repeat (v.p1) step(1'b1, 1'b1);
    if (v.p2 > 0) begin
      repeat (v.gap) step(1'b0, 1'b1);
      repeat (v.p2) step(1'b1, 1'b1);
    end
    repeat (v.tail) step(1'b0, 1'b1);
    chk_int({v.name, "_press"}, sc_press, v.n_press);
    chk_int({v.name, "_release"}, sc_rel, v.n_rel);
    chk_int({v.name, "_click"}, sc_click, v.n_click);
    chk_int({v.name, "_dbl"}, sc_dbl, v.n_dbl);
    chk_int({v.name, "_long"}, sc_long, v.n_long);
    chk_int({v.name, "_repeat"}, sc_rep, v.n_rep);
    chk_int({v.name, "_click_off"}, sc_click_off, v.click_off);
    chk_int({v.name, "_long_off"}, sc_long_off, v.long_off);
  endtask

  vec_t vecs [8];

  initial begin
    int ph, rl;
    vecs[0] = '{"tap",         5,  0,  0, 25, 1, 1, 1, 0, 0, 0, 10, -1};
    vecs[1] = '{"double",      5,  4,  5, 25, 2, 2, 0, 1, 0, 0, -1, -1};
    vecs[2] = '{"hold40",     40,  0,  0, 25, 1, 1, 0, 0, 1, 3, -1, 20};
    vecs[3] = '{"rel_at_long",20,  0,  0, 25, 1, 1, 1, 0, 0, 0, 10, -1};
    vecs[4] = '{"hold21",     21,  0,  0, 25, 1, 1, 0, 0, 1, 0, -1, 20};
    vecs[5] = '{"gap10",       5, 10,  5, 25, 2, 2, 0, 1, 0, 0, -1, -1};
    vecs[6] = '{"gap11",       5, 11,  5, 25, 2, 2, 2, 0, 0, 0, 10, -1};
    vecs[7] = '{"dbl_long",    5,  3, 27, 25, 2, 2, 1, 0, 1, 1, 23, 20};

    repeat (4) step(1'b0, 1'b0);
    chk_vec("reset_state_al0", obs_hi, 7'b0);
    step(1'b0, 1'b1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of a held first press, then release reset with the key held.
    repeat (3) step(1'b0, 1'b1);
    repeat (6) step(1'b1, 1'b1);
    @(posedge clk); #2;
    chk_vec("pre_reset_pressed", {6'b0, kp_h}, 7'b1);
    rst_n = 1'b0;
    #1;
    chk_vec("async_reset_al0", {kp_h, pr_h, rl_h, ck_h, db_h, lg_h, rp_h}, 7'b0);
    chk_vec("async_reset_al1", {kp_l, pr_l, rl_l, ck_l, db_l, lg_l, rp_l}, 7'b0);
    rstv[cyc] = 1'b0;
    hist[cyc] = 1'b0;
    repeat (4) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    chk_vec("no_press_2_edges", {6'b0, obs_hi[5]}, 7'b0);
    step(1'b1, 1'b1);
    chk_vec("press_3_edges", {6'b0, obs_hi[5]}, 7'b1);
    repeat (25) step(1'b0, 1'b1);

    for (int i = 0; i < 150; i++) begin
      ph = $urandom_range(1, 45);
      rl = $urandom_range(1, 16);
      repeat (ph) step(1'b1, 1'b1);
      repeat (rl) step(1'b0, 1'b1);
    end
    repeat (30) step(1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
